// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready operand and result handshakes.
// Logic/arith ops take one cycle; shifts iterate one bit per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_SHIFT | iterative shifter running, cnt_q = shifts still to apply
// ST_DONE  | result/zero held, out_valid high until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic             sra_sel,
  input  logic             unsigned_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRX = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shl_q, shl_d;
  logic               arith_q, arith_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               in_left;
  logic               in_arith;
  logic               lt;
  logic [WIDTH-1:0]   alu_res;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic left,
                                              input logic arith);
    if (left) begin
      return {v[WIDTH-2:0], 1'b0};
    end
    return {arith ? v[WIDTH-1] : 1'b0, v[WIDTH-1:1]};
  endfunction

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHAMT_W-1:0];
  assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRX);
  assign in_left  = (alu_control == OP_SLL);
  assign in_arith = (alu_control == OP_SRX) && sra_sel;
  assign lt       = unsigned_sel ? (src_a < src_b) : ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_res = src_a;
    case (alu_control)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_XOR:  alu_res = src_a ^ src_b;
      default: alu_res = src_a;
    endcase
  end

  // The first shift is applied in the accept cycle, so an N-bit shift
  // presents out_valid N cycles after accept, matching 1-cycle ops at N=1.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    arith_d  = arith_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shl_d   = in_left;
          arith_d = in_arith;
          if (!is_shift) begin
            result_d = alu_res;
            state_d  = ST_DONE;
          end else if (shamt == '0) begin
            result_d = src_a;
            state_d  = ST_DONE;
          end else begin
            result_d = shift1(src_a, in_left, in_arith);
            cnt_d    = shamt - SHAMT_W'(1);
            state_d  = (shamt == SHAMT_W'(1)) ? ST_DONE : ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        result_d = shift1(result_q, shl_q, arith_q);
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      arith_q  <= arith_d;
    end
  end

endmodule
